// File: rtl/vector_ram_arbiter_if.sv
// Bundle of CPU, vector-generator, BRAM and sequencing signals around the
// shared vector RAM. The arbiter takes the slave side; the environment
// (CPU, generator and BRAM) takes the master side.
interface vector_ram_arbiter_if #(
  parameter int ADDR_W = 12
) ();
  // CPU port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [7:0]        cpu_wdata;
  logic              cpu_gnt;
  logic [7:0]        cpu_rdata;
  logic              cpu_rvalid;
  // Vector-generator read port
  logic              vg_req;
  logic [ADDR_W-1:0] vg_addr;
  logic              vg_gnt;
  logic [7:0]        vg_rdata;
  logic              vg_rvalid;
  // Single BRAM port
  logic              bram_en;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [7:0]        bram_wdata;
  logic [7:0]        bram_rdata;
  // Generator sequencing
  logic              vggo;
  logic              vgrst;
  logic              vg_done;
  logic              vg_run;
  logic              halt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid,
    input  vg_req, vg_addr,
    output vg_gnt, vg_rdata, vg_rvalid,
    output bram_en, bram_we, bram_addr, bram_wdata,
    input  bram_rdata,
    input  vggo, vgrst, vg_done,
    output vg_run, halt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid,
    output vg_req, vg_addr,
    input  vg_gnt, vg_rdata, vg_rvalid,
    input  bram_en, bram_we, bram_addr, bram_wdata,
    output bram_rdata,
    output vggo, vgrst, vg_done,
    input  vg_run, halt
  );
endinterface

// File: rtl/vector_ram_arbiter.sv
// Arbiter sharing one BRAM port between the CPU (read/write, default
// priority) and the vector generator (read-only, priority once starved for
// STARVE_LIMIT consecutive cycles). Also sequences the generator IDLE/RUN.
module vector_ram_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  vector_ram_arbiter_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic        cpu_rvalid_q, cpu_rvalid_d;
  logic        vg_rvalid_q, vg_rvalid_d;

  logic        run;
  logic        cpu_req_eff;
  logic        vg_req_eff;
  logic        vg_pri;
  logic        cpu_gnt;
  logic        vg_gnt;

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Sequencer next state: vgrst dominates, vggo only heard while idle
  always_comb begin
    state_d = state_q;
    if (bus.vgrst)                          state_d = IDLE;
    else if (state_q == IDLE && bus.vggo)   state_d = RUN;
    else if (state_q == RUN && bus.vg_done) state_d = IDLE;
  end

  // Sequencer outputs
  always_comb begin
    run = (state_q == RUN);
  end

  assign bus.vg_run = run;
  assign bus.halt   = ~run;

  // Arbitration: requests are masked during reset; generator only counts while running
  always_comb begin
    cpu_req_eff = rst_n & bus.cpu_req;
    vg_req_eff  = rst_n & run & bus.vg_req;
    vg_pri      = (starve_q == LIMIT);
    vg_gnt      = vg_req_eff & (vg_pri | ~cpu_req_eff);
    cpu_gnt     = cpu_req_eff & ~vg_gnt;
  end

  // BRAM port mux: idle port is driven to zero, generator never writes
  always_comb begin
    bus.bram_en    = cpu_gnt | vg_gnt;
    bus.bram_we    = cpu_gnt & bus.cpu_we;
    bus.bram_addr  = '0;
    bus.bram_wdata = '0;
    if (cpu_gnt) begin
      bus.bram_addr  = bus.cpu_addr;
      bus.bram_wdata = bus.cpu_wdata;
    end else if (vg_gnt) begin
      bus.bram_addr  = bus.vg_addr;
    end
  end

  // Starvation counter and read-valid strobes for the next cycle
  always_comb begin
    starve_d     = starve_q;
    if (vg_gnt || bus.vgrst)                 starve_d = '0;
    else if (vg_req_eff && starve_q < LIMIT) starve_d = starve_q + 3'd1;
    cpu_rvalid_d = cpu_gnt & ~bus.cpu_we;
    vg_rvalid_d  = vg_gnt;
  end

  // Counter and read-valid registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q     <= '0;
      cpu_rvalid_q <= 1'b0;
      vg_rvalid_q  <= 1'b0;
    end else begin
      starve_q     <= starve_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      vg_rvalid_q  <= vg_rvalid_d;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.vg_gnt     = vg_gnt;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.vg_rvalid  = vg_rvalid_q;
  assign bus.cpu_rdata  = bus.bram_rdata;
  assign bus.vg_rdata   = bus.bram_rdata;

endmodule
